// File: rtl/pipeline_debug_ctrl.sv
// Purpose : host-byte-driven run/step/reset/dump controller for the 5-stage MIPS pipeline.
// Latency : commands act the cycle after acceptance; each reg/mem dump word costs 2 LOAD cycles.
// Backpressure: o_rx_ready only in IDLE; dump/ack bytes wait on i_tx_ready with o_tx_data held.
//
// Ports:
//   i_clock, i_reset (async, active-low)
//   i_rx_data/i_rx_valid/o_rx_ready : command byte stream (0x01 RUN, 0x02 STEP, 0x03 DUMP, 0x04 RESET)
//   o_tx_data/o_tx_valid/i_tx_ready : dump (and optional ack) byte stream, MSB first per word
//   o_pipe_valid, o_pipe_reset, i_halt, i_pc : pipeline enable, reset pulse, HALT retire, fetch PC
//   o_dbg_reg_addr/i_dbg_reg_data, o_dbg_mem_addr/i_dbg_mem_data : debug read ports, 1-cycle read latency
//   o_cycle_count (saturating enabled-cycle count), o_halted (sticky)
// Optional: define DBG_ACK_EN to emit 0xA1/0xA2/0xA4 after RUN-halt/STEP/RESET completion.
module pipeline_debug_ctrl #(
  parameter int NB_REG        = 32,
  parameter int NB_BYTE       = 8,
  parameter int NB_REG_ADDR   = 5,
  parameter int REGFILE_DEPTH = 32,
  parameter int NB_DMEM_ADDR  = 11,
  parameter int N_DUMP_WORDS  = 16
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic [NB_BYTE-1:0]      i_rx_data,
  input  logic                    i_rx_valid,
  output logic                    o_rx_ready,
  output logic [NB_BYTE-1:0]      o_tx_data,
  output logic                    o_tx_valid,
  input  logic                    i_tx_ready,
  output logic                    o_pipe_valid,
  output logic                    o_pipe_reset,
  input  logic                    i_halt,
  input  logic [NB_REG-1:0]       i_pc,
  output logic [NB_REG_ADDR-1:0]  o_dbg_reg_addr,
  input  logic [NB_REG-1:0]       i_dbg_reg_data,
  output logic [NB_DMEM_ADDR-1:0] o_dbg_mem_addr,
  input  logic [NB_REG-1:0]       i_dbg_mem_data,
  output logic [NB_REG-1:0]       o_cycle_count,
  output logic                    o_halted
);
  localparam int NBYTES    = NB_REG / NB_BYTE;
  localparam int BIDX_W    = $clog2(NBYTES + 1);
  localparam int N_ITEMS   = 2 + REGFILE_DEPTH + N_DUMP_WORDS;  // PC, count, regs, mem words
  localparam int ITEM_W    = $clog2(N_ITEMS + 1);
  localparam int FIRST_MEM = 2 + REGFILE_DEPTH;

  localparam logic [NB_BYTE-1:0] CMD_RUN  = NB_BYTE'(8'h01);
  localparam logic [NB_BYTE-1:0] CMD_STEP = NB_BYTE'(8'h02);
  localparam logic [NB_BYTE-1:0] CMD_DUMP = NB_BYTE'(8'h03);
  localparam logic [NB_BYTE-1:0] CMD_RST  = NB_BYTE'(8'h04);
  localparam logic [NB_BYTE-1:0] ACK_BASE = NB_BYTE'(8'hA0);

`ifdef DBG_ACK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_STEP, S_PRST, S_LOAD, S_SEND} state_t;

  state_t              state, state_nxt;
  logic [NB_REG-1:0]   shreg;       // outgoing word, top byte is on o_tx_data
  logic [NB_REG-1:0]   cnt_cap;     // cycle count frozen at DUMP accept
  logic [BIDX_W-1:0]   byte_idx;
  logic [ITEM_W-1:0]   item;
  logic [ITEM_W-1:0]   item_inc;
  logic                load_phase;  // 0: address on bus, 1: read data valid
  logic                ack_pend;    // SEND is carrying a single ack byte, not dump data
  logic [NB_BYTE-1:0]  ack_code;
  logic                halt_fin, dump_go, tx_fire, last_byte, last_item;

  assign o_tx_data = shreg[NB_REG-1 -: NB_BYTE];

  always_comb begin
    state_nxt = state;
    ack_code  = ACK_BASE;
    halt_fin  = 1'b0;
    dump_go   = 1'b0;
    tx_fire   = 1'b0;
    last_byte = (byte_idx == BIDX_W'(NBYTES - 1));
    last_item = (item == ITEM_W'(N_ITEMS - 1));
    item_inc  = item + 1'b1;
    case (state)
      S_IDLE: begin
        if (i_rx_valid) begin
          case (i_rx_data)
            CMD_RUN:  if (!o_halted) state_nxt = S_RUN;
            CMD_STEP: if (!o_halted) state_nxt = S_STEP;
            CMD_DUMP: begin
              state_nxt = S_SEND;
              dump_go   = 1'b1;
            end
            CMD_RST:  state_nxt = S_PRST;
            default:  state_nxt = S_IDLE;
          endcase
        end
      end
      S_RUN: begin
        ack_code = ACK_BASE | CMD_RUN;
        if (i_halt) begin
          halt_fin  = 1'b1;
          state_nxt = ACK_EN ? S_SEND : S_IDLE;
        end
      end
      S_STEP: begin
        ack_code  = ACK_BASE | CMD_STEP;
        halt_fin  = 1'b1;
        state_nxt = ACK_EN ? S_SEND : S_IDLE;
      end
      S_PRST: begin
        ack_code  = ACK_BASE | CMD_RST;
        halt_fin  = 1'b1;
        state_nxt = ACK_EN ? S_SEND : S_IDLE;
      end
      S_LOAD: if (load_phase) state_nxt = S_SEND;
      S_SEND: begin
        if (i_tx_ready) begin
          tx_fire = 1'b1;
          if (ack_pend || (last_byte && last_item)) state_nxt = S_IDLE;
          // the cycle-count item is already captured, only reg/mem items need a read
          else if (last_byte) state_nxt = (item_inc == ITEM_W'(1)) ? S_SEND : S_LOAD;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State and Moore outputs, all decoded from the next state so they come straight off flops.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state        <= S_IDLE;
      o_rx_ready   <= 1'b1;
      o_tx_valid   <= 1'b0;
      o_pipe_valid <= 1'b0;
      o_pipe_reset <= 1'b0;
    end else begin
      state        <= state_nxt;
      o_rx_ready   <= (state_nxt == S_IDLE);
      o_tx_valid   <= (state_nxt == S_SEND);
      o_pipe_valid <= (state_nxt == S_RUN) || (state_nxt == S_STEP);
      o_pipe_reset <= (state_nxt == S_PRST);
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_cycle_count  <= '0;
      o_halted       <= 1'b0;
      shreg          <= '0;
      cnt_cap        <= '0;
      byte_idx       <= '0;
      item           <= '0;
      load_phase     <= 1'b0;
      ack_pend       <= 1'b0;
      o_dbg_reg_addr <= '0;
      o_dbg_mem_addr <= '0;
    end else begin
      if (state == S_PRST) begin
        o_cycle_count <= '0;
        o_halted      <= 1'b0;
      end else if (o_pipe_valid) begin
        if (o_cycle_count != '1) o_cycle_count <= o_cycle_count + 1'b1;
        if (i_halt) o_halted <= 1'b1;
      end

      if (dump_go) begin
        shreg    <= i_pc;
        cnt_cap  <= o_cycle_count;
        item     <= '0;
        byte_idx <= '0;
        ack_pend <= 1'b0;
      end

      if (ACK_EN && halt_fin) begin
        shreg    <= NB_REG'(ack_code) << (NB_REG - NB_BYTE);
        byte_idx <= '0;
        ack_pend <= 1'b1;
      end

      if (state == S_LOAD) begin
        load_phase <= ~load_phase;
        if (load_phase) shreg <= (item < ITEM_W'(FIRST_MEM)) ? i_dbg_reg_data : i_dbg_mem_data;
      end

      if (tx_fire) begin
        shreg    <= shreg << NB_BYTE;
        byte_idx <= byte_idx + 1'b1;
        if (ack_pend) begin
          ack_pend <= 1'b0;
        end else if (last_byte && !last_item) begin
          item     <= item_inc;
          byte_idx <= '0;
          if (item_inc == ITEM_W'(1)) begin
            shreg <= cnt_cap;
          end else begin
            load_phase <= 1'b0;
            if (item_inc < ITEM_W'(FIRST_MEM))
              o_dbg_reg_addr <= NB_REG_ADDR'(item_inc - ITEM_W'(2));
            else
              o_dbg_mem_addr <= NB_DMEM_ADDR'(item_inc - ITEM_W'(FIRST_MEM));
          end
        end
      end
    end
  end
endmodule

// File: doc/pipeline_debug_ctrl.md
Name: pipeline_debug_ctrl

Overview:
Debug/run controller sequencing the 5-stage MIPS pipeline from a host byte stream (UART side). Decodes single-byte commands to run the pipeline until HALT, single-step it, reset it, or dump PC, cycle count, register file and a data-memory window back as bytes. Owns the pipeline's valid/enable and a synchronous pipeline reset pulse.

Parameters:
NB_REG, 32, datapath/word width; must be a multiple of 8
NB_BYTE, 8, host byte width
NB_REG_ADDR, 5, register file address width
REGFILE_DEPTH, 32, registers dumped (addresses 0..REGFILE_DEPTH-1)
NB_DMEM_ADDR, 11, data memory word-address width
N_DUMP_WORDS, 16, data-memory words dumped (word addresses 0..N_DUMP_WORDS-1)

Ports:
i_clock  in  1  clock
i_reset  in  1  asynchronous, active-low reset
i_rx_data  in  NB_BYTE  command byte
i_rx_valid  in  1  command byte valid
o_rx_ready  out  1  controller accepts a command
o_tx_data  out  NB_BYTE  dump/ack byte
o_tx_valid  out  1  tx byte valid
i_tx_ready  in  1  host accepts tx byte
o_pipe_valid  out  1  pipeline enable (to pipeline i_valid)
o_pipe_reset  out  1  one-cycle synchronous reset pulse to pipeline
i_halt  in  1  HALT instruction retired in pipeline
i_pc  in  NB_REG  current fetch PC
o_dbg_reg_addr  out  NB_REG_ADDR  register file debug read address
i_dbg_reg_data  in  NB_REG  register data, valid 1 cycle after address
o_dbg_mem_addr  out  NB_DMEM_ADDR  data memory debug read address
i_dbg_mem_data  in  NB_REG  memory data, valid 1 cycle after address
o_cycle_count  out  NB_REG  enabled-cycle counter
o_halted  out  1  sticky halt flag

Behaviour:
- Reset (i_reset=0, async): state IDLE; all outputs 0 except o_rx_ready=1; counter, halted flag, dump indices, shift register cleared. Reset mid-run or mid-dump aborts immediately; no partial byte completes.
- Handshakes: rx byte accepted when i_rx_valid & o_rx_ready; tx byte transferred when o_tx_valid & i_tx_ready; o_tx_data stable while o_tx_valid=1 and not accepted.
- o_rx_ready=1 only in IDLE. Commands: 0x01 RUN, 0x02 STEP, 0x03 DUMP, 0x04 RESET; any other byte consumed and ignored (stay IDLE). RUN/STEP while o_halted=1 consumed and ignored.
- States: IDLE, RUN, STEP, PRST, LOAD, SEND. All outputs registered (Moore).
- RUN: o_pipe_valid=1 every cycle in RUN. If i_halt=1 sampled in RUN: o_halted<=1, next state IDLE (that cycle is still an enabled cycle).
- STEP: exactly one cycle o_pipe_valid=1, then IDLE; i_halt sampled in that cycle sets o_halted.
- PRST: o_pipe_reset=1 for exactly one cycle; o_cycle_count<=0, o_halted<=0; then IDLE.
- o_cycle_count: +1 per cycle with o_pipe_valid=1; saturates at 2^NB_REG-1 (no wrap).
- DUMP sequence, items in order: PC (i_pc captured at command accept), o_cycle_count (captured at accept), regs 0..REGFILE_DEPTH-1, mem words 0..N_DUMP_WORDS-1. Per reg/mem item: LOAD drives address for 1 cycle, word latched next cycle into shift register; SEND emits NB_REG/8 bytes MSB first, one per tx handshake. After last byte of last item -> IDLE. Default length: 4*(2+32+16)=200 bytes.
- o_pipe_valid=0 in all states except RUN/STEP; pipeline frozen during dump.
- o_dbg_reg_addr/o_dbg_mem_addr hold last value outside LOAD.

Optional Feature:
DBG_ACK_EN: when defined, on completion of RUN (halt reached), STEP and RESET the controller enters SEND with one byte 8'hA0|cmd (0xA1, 0xA2, 0xA4) before returning to IDLE; o_rx_ready stays 0 until acked byte transferred. Undefined: no ack bytes; only DUMP produces tx traffic, and completion returns directly to IDLE.

Test Plan:
- Reset: hold i_reset=0 mid-DUMP with i_tx_ready=0 -> o_tx_valid=0, o_rx_ready=1, o_cycle_count=0 on release.
- RUN with i_halt asserted on 10th enabled cycle -> o_pipe_valid high exactly 10 cycles, o_cycle_count=10, o_halted=1; a further 0x01 leaves count at 10.
- STEP x3 then RESET (0x04) -> count 3 after steps, o_pipe_reset one cycle, count 0, o_halted 0.
- DUMP with i_pc=0x0000_0040, count 5, reg[k]=k, mem[k]=0x1000+k, i_tx_ready random -> 200 bytes: 00 00 00 40, 00 00 00 05, 00 00 00 00 ... 00 00 10 0F, no byte lost or duplicated.
- Unknown byte 0x7F -> consumed, no tx, o_pipe_valid stays 0; RUN with counter preset near 0xFFFF_FFFF -> saturates at 0xFFFF_FFFF.
- With DBG_ACK_EN: STEP -> tx byte 0xA2, o_rx_ready low until accepted.
